// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and byte-merge helper for the dual-port data memory
package mem_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend in and truncate out.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    // Replace every byte of old_word whose enable is set with the matching byte of new_data.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_data,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - per-port read output stage: optional output register, rvalid shift, q hold
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req            : read accepted on this edge
//   word           : word sampled on the accepting edge
//   q, rvalid      : read data (held between reads) and one-cycle valid pulse
module mem_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] q,
    output logic              rvalid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;

    // Data only moves when a read lands, so q holds its last value otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= req;
            if (req) begin
                s1_data <= word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data;
            logic              s2_vld;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s2_data <= '0;
                    s2_vld  <= 1'b0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign q      = s2_data;
            assign rvalid = s2_vld;
        end else begin : g_no_out_reg
            assign q      = s1_data;
            assign rvalid = s1_vld;
        end
    endgenerate

endmodule

// File: rtl/mem_dp_be.sv
// rtl/mem_dp_be.sv - true dual-port byte-enabled RAM with post-reset clear engine
//
// Ports:
//   clock, reset_n     : clock and asynchronous active-low reset
//   init_busy          : clear engine running; all requests ignored
//   address_x, byteena_x, data_x, wren_x, rden_x : port x request (x = a, b)
//   q_x, rvalid_x      : port x read data and read-valid pulse
module mem_dp_be
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 32,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [BE_W-1:0]   byteena_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DATA_W-1:0] q_a,
    output logic              rvalid_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [BE_W-1:0]   byteena_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_b,
    output logic              rvalid_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_t  state, state_nxt;
    logic [ADDR_W:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The extra counter bit flips exactly when the last word has been written.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + (ADDR_W+1)'(1);
            if (clr_cnt_nxt[ADDR_W]) begin
                state_nxt = READY;
            end
        end
    end

    assign init_busy = (state == CLEAR);

    logic wr_a, wr_b, rd_a, rd_b;
    assign wr_a = wren_a && (state == READY);
    assign wr_b = wren_b && (state == READY);
    assign rd_a = rden_a && (state == READY);
    assign rd_b = rden_b && (state == READY);

    logic [DATA_W-1:0] old_a, old_b, base_a;
    logic [DATA_W-1:0] wr_word_a, wr_word_b, rd_word_a, rd_word_b;

    assign old_a = mem[address_a];
    assign old_b = mem[address_b];

    // On a same-word collision A merges on top of B's result, so A wins
    // overlapping bytes and B-only bytes survive.
    assign base_a    = (wr_b && (address_b == address_a)) ? wr_word_b : old_a;
    assign wr_word_b = DATA_W'(be_merge(MAX_DATA_W'(old_b), MAX_DATA_W'(data_b), MAX_BE_W'(byteena_b)));
    assign wr_word_a = DATA_W'(be_merge(MAX_DATA_W'(base_a), MAX_DATA_W'(data_a), MAX_BE_W'(byteena_a)));

    // Cross-port reads always see the pre-write word; only a port's own write
    // can be forwarded, and only in new-data mode.
    assign rd_word_a = (RDW_MODE == RDW_NEW && wr_a)
                     ? DATA_W'(be_merge(MAX_DATA_W'(old_a), MAX_DATA_W'(data_a), MAX_BE_W'(byteena_a)))
                     : old_a;
    assign rd_word_b = (RDW_MODE == RDW_NEW && wr_b)
                     ? DATA_W'(be_merge(MAX_DATA_W'(old_b), MAX_DATA_W'(data_b), MAX_BE_W'(byteena_b)))
                     : old_b;

    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (wr_b) begin
                mem[address_b] <= wr_word_b;
            end
            if (wr_a) begin
                mem[address_a] <= wr_word_a;
            end
        end
    end

    mem_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_pipe_a (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_a),
        .word    (rd_word_a),
        .q       (q_a),
        .rvalid  (rvalid_a)
    );

    mem_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_pipe_b (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_b),
        .word    (rd_word_b),
        .q       (q_b),
        .rvalid  (rvalid_b)
    );

endmodule

// File: tb/tb_mem_dp_be.sv
// tb/tb_mem_dp_be.sv - directed self-checking bench for mem_dp_be (two configurations, shared stimulus)
module tb_mem_dp_be;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  address_a, address_b;
    logic [3:0]  byteena_a, byteena_b;
    logic [31:0] data_a, data_b;
    logic        wren_a, wren_b, rden_a, rden_b;

    logic        busy0, rv_a0, rv_b0, busy1, rv_a1, rv_b1;
    logic [31:0] q_a0, q_b0, q_a1, q_b1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    // dut0: latency 1, old-data read-during-write
    mem_dp_be #(.ADDR_W(4), .DATA_W(32), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .init_busy(busy0),
        .address_a(address_a), .byteena_a(byteena_a), .data_a(data_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a0), .rvalid_a(rv_a0),
        .address_b(address_b), .byteena_b(byteena_b), .data_b(data_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b0), .rvalid_b(rv_b0)
    );

    // dut1: latency 2, new-data read-during-write
    mem_dp_be #(.ADDR_W(4), .DATA_W(32), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .init_busy(busy1),
        .address_a(address_a), .byteena_a(byteena_a), .data_a(data_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a1), .rvalid_a(rv_a1),
        .address_b(address_b), .byteena_b(byteena_b), .data_b(data_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b1), .rvalid_b(rv_b1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        byteena_a = 4'h0; byteena_b = 4'h0;
        data_a = 32'h0; data_b = 32'h0;
        address_a = 4'h0; address_b = 4'h0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h9E3779B9 * 32'(i + 1);
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (3) tick();

        // Reset state
        chk("rst busy0", 32'(busy0), 32'd1);
        chk("rst busy1", 32'(busy1), 32'd1);
        chk("rst q_a0", q_a0, 32'h0);
        chk("rst rv_a0", 32'(rv_a0), 32'd0);
        chk("rst q_b1", q_b1, 32'h0);
        chk("rst rv_b1", 32'(rv_b1), 32'd0);

        // Clear lasts exactly 16 cycles; a read of word 5 during busy is dropped
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) begin address_a = 4'd5; rden_a = 1'b1; end
            if (k == 3) rden_a = 1'b0;
            tick();
            chk($sformatf("clr busy0 k=%0d", k), 32'(busy0), (k < 16) ? 32'd1 : 32'd0);
            chk($sformatf("clr busy1 k=%0d", k), 32'(busy1), (k < 16) ? 32'd1 : 32'd0);
            chk($sformatf("clr rv_a0 k=%0d", k), 32'(rv_a0), 32'd0);
            chk($sformatf("clr rv_a1 k=%0d", k), 32'(rv_a1), 32'd0);
        end

        // All words read back as zero after clear
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                address_a = 4'(i); address_b = 4'(15 - i); rden_a = 1'b1; rden_b = 1'b1;
            end else begin
                rden_a = 1'b0; rden_b = 1'b0;
            end
            tick();
            if (i < 16) begin
                chk("zero rv_a0", 32'(rv_a0), 32'd1);
                chk("zero q_a0", q_a0, 32'h0);
                chk("zero q_b0", q_b0, 32'h0);
            end
            if (i >= 1) begin
                chk("zero rv_b1", 32'(rv_b1), 32'd1);
                chk("zero q_b1", q_b1, 32'h0);
            end
        end

        // Byte-enabled writes on A, read on B; latency per configuration
        idle();
        address_a = 4'd3; data_a = 32'hDEADBEEF; byteena_a = 4'b1111; wren_a = 1'b1;
        tick();
        data_a = 32'h11223344; byteena_a = 4'b0101;
        tick();
        data_a = 32'hFFFFFFFF; byteena_a = 4'b0000;
        tick();
        idle();
        address_b = 4'd3; rden_b = 1'b1;
        tick();
        rden_b = 1'b0;
        chk("be rv_b0 lat1", 32'(rv_b0), 32'd1);
        chk("be q_b0", q_b0, 32'hDE22BE44);
        chk("be rv_b1 early", 32'(rv_b1), 32'd0);
        tick();
        chk("be rv_b0 pulse", 32'(rv_b0), 32'd0);
        chk("be q_b0 hold", q_b0, 32'hDE22BE44);
        chk("be rv_b1 lat2", 32'(rv_b1), 32'd1);
        chk("be q_b1", q_b1, 32'hDE22BE44);

        // Read-during-write on word 7, same port and cross port
        address_a = 4'd7; data_a = 32'hAAAAAAAA; byteena_a = 4'b1111; wren_a = 1'b1;
        tick();
        data_a = 32'h55555555; rden_a = 1'b1;
        address_b = 4'd7; rden_b = 1'b1;
        tick();
        idle();
        chk("rdw q_a0 old", q_a0, 32'hAAAAAAAA);
        chk("rdw q_b0 cross", q_b0, 32'hAAAAAAAA);
        tick();
        chk("rdw q_a1 new", q_a1, 32'h55555555);
        chk("rdw q_b1 cross", q_b1, 32'hAAAAAAAA);

        // Write collisions: word 9 from zero, word 10 from a known value
        address_a = 4'd10; data_a = 32'h99887766; byteena_a = 4'b1111; wren_a = 1'b1;
        tick();
        address_a = 4'd9; data_a = 32'h000000FF; byteena_a = 4'b0011;
        address_b = 4'd9; data_b = 32'h12345678; byteena_b = 4'b0110; wren_b = 1'b1;
        tick();
        address_a = 4'd10; address_b = 4'd10;
        tick();
        idle();
        address_a = 4'd9; address_b = 4'd10; rden_a = 1'b1; rden_b = 1'b1;
        tick();
        idle();
        chk("col q_a0 w9", q_a0, 32'h003400FF);
        chk("col q_b0 w10", q_b0, 32'h993400FF);
        tick();
        chk("col q_a1 w9", q_a1, 32'h003400FF);
        chk("col q_b1 w10", q_b1, 32'h993400FF);

        // Fill all words via B, then back-to-back reads on both ports
        for (int i = 0; i < 16; i++) begin
            address_b = 4'(i); data_b = pat(i); byteena_b = 4'b1111; wren_b = 1'b1;
            tick();
        end
        idle();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                address_a = 4'(i); address_b = 4'(15 - i); rden_a = 1'b1; rden_b = 1'b1;
            end else begin
                rden_a = 1'b0; rden_b = 1'b0;
            end
            tick();
            if (i < 16) begin
                chk($sformatf("b2b rv_a0 i=%0d", i), 32'(rv_a0), 32'd1);
                chk($sformatf("b2b rv_b0 i=%0d", i), 32'(rv_b0), 32'd1);
                chk($sformatf("b2b q_a0 i=%0d", i), q_a0, pat(i));
                chk($sformatf("b2b q_b0 i=%0d", i), q_b0, pat(15 - i));
            end else begin
                chk("b2b rv_a0 end", 32'(rv_a0), 32'd0);
            end
            if (i >= 1) begin
                chk($sformatf("b2b rv_a1 i=%0d", i), 32'(rv_a1), 32'd1);
                chk($sformatf("b2b rv_b1 i=%0d", i), 32'(rv_b1), 32'd1);
                chk($sformatf("b2b q_a1 i=%0d", i), q_a1, pat(i - 1));
                chk($sformatf("b2b q_b1 i=%0d", i), q_b1, pat(16 - i));
            end
        end
        tick();
        chk("b2b rv_a1 end", 32'(rv_a1), 32'd0);
        chk("b2b q_a1 hold", q_a1, pat(15));

        // Asynchronous reset clears outputs immediately
        reset_n = 1'b0;
        #1;
        chk("arst q_a1", q_a1, 32'h0);
        chk("arst q_b0", q_b0, 32'h0);
        chk("arst busy0", 32'(busy0), 32'd1);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("mid busy0", 32'(busy0), 32'd1);

        // Abort at cycle 8 of the clear, then a full 16-cycle restart
        reset_n = 1'b0;
        #1;
        chk("abort rv_a0", 32'(rv_a0), 32'd0);
        chk("abort busy1", 32'(busy1), 32'd1);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("reclr busy0 k=%0d", k), 32'(busy0), (k < 16) ? 32'd1 : 32'd0);
            chk($sformatf("reclr busy1 k=%0d", k), 32'(busy1), (k < 16) ? 32'd1 : 32'd0);
        end

        // Words beyond the aborted point are cleared again
        address_a = 4'd15; address_b = 4'd12; rden_a = 1'b1; rden_b = 1'b1;
        tick();
        idle();
        chk("reclr rv_a0", 32'(rv_a0), 32'd1);
        chk("reclr q_a0 w15", q_a0, 32'h0);
        chk("reclr q_b0 w12", q_b0, 32'h0);
        tick();
        chk("reclr rv_b1", 32'(rv_b1), 32'd1);
        chk("reclr q_b1 w12", q_b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
